mem_access_stage: RTL

//  MEM-stage consumer of the EX/MEM pipeline register: the read side of the EX->MEM boundary.

---
 rtl/mem_access_stage_if.sv | 13 +
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory or its model (slave).
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data bus for loads/stores, extends load data, registers MEM/WB.
// Zero-wait access completes in 1 cycle; slow memory stalls upstream until ready or timeout.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  ResultSrc_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [31:0] PCPlus4_i,
  input  logic [31:0] ImmExt_i,
  input  logic [4:0]  Rd_i,
  mem_access_stage_if.master dmem,
  output logic        stall_mem_o,
  output logic        wb_RegWrite_o,
  output logic [1:0]  wb_ResultSrc_o,
  output logic [31:0] wb_ReadData_o,
  output logic [31:0] wb_ALUResult_o,
  output logic [31:0] wb_PCPlus4_o,
  output logic [31:0] wb_ImmExt_o,
  output logic [4:0]  wb_Rd_o,
  output logic        mem_err_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
  } wb_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  wb_t           wb_q, wb_d;
  logic          err_q, err_d;

  logic        is_load, is_store, access, f3_ok, misaligned, good;
  logic        req_c, stall_c, complete, timeout, capture;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, rshift, load_ext;
  logic [15:0] half_sel;

  assign is_load  = (ResultSrc_i == 2'b01);
  assign is_store = MemWrite_i;
  assign access   = is_load | is_store;
  assign f3_ok    = is_store ? (funct3_i inside {3'b000, 3'b001, 3'b010})
                             : (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = ((funct3_i[1:0] == 2'b01) && ALUResult_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (ALUResult_i[1:0] != 2'b00));
  assign good = access & f3_ok & ~misaligned;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteData_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResult_i[1:0];
        wdata_c = {4{WriteData_i[7:0]}};
      end
      2'b01: begin
        be_c    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{WriteData_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rshift   = dmem.rdata >> {ALUResult_i[1:0], 3'b000};
  assign half_sel = ALUResult_i[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

  always_comb begin
    case (funct3_i)
      3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  load_ext = {24'b0, rshift[7:0]};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = dmem.rdata;
    endcase
  end

  // The timeout cycle keeps req up so a late ready still completes; stall drops so the bubble retires.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (good) begin
          req_c = 1'b1;
          if (dmem.ready) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (dmem.ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign capture = ((state_q == S_IDLE) & ~access) | complete;

  always_comb begin
    wb_d = '0;
    if (capture) begin
      wb_d.reg_write  = RegWrite_i;
      wb_d.result_src = ResultSrc_i;
      wb_d.read_data  = is_load ? load_ext : 32'b0;
      wb_d.alu_result = ALUResult_i;
      wb_d.pc_plus4   = PCPlus4_i;
      wb_d.imm_ext    = ImmExt_i;
      wb_d.rd         = Rd_i;
    end
    err_d = ((state_q == S_IDLE) & access & ~good) | timeout;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  // Reset gates the combinational outputs so an aborted access disappears immediately.
  assign dmem.req    = req_c & ~rst_i;
  assign dmem.we     = is_store;
  assign dmem.addr   = {ALUResult_i[31:2], 2'b00};
  assign dmem.wdata  = wdata_c;
  assign dmem.be     = is_store ? be_c : 4'b0000;
  assign stall_mem_o = stall_c & ~rst_i;

  assign wb_RegWrite_o  = wb_q.reg_write;
  assign wb_ResultSrc_o = wb_q.result_src;
  assign wb_ReadData_o  = wb_q.read_data;
  assign wb_ALUResult_o = wb_q.alu_result;
  assign wb_PCPlus4_o   = wb_q.pc_plus4;
  assign wb_ImmExt_o    = wb_q.imm_ext;
  assign wb_Rd_o        = wb_q.rd;
  assign mem_err_o      = err_q;
endmodule
